// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked sharing of one UART transmitter
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic                 ack_err
);
    localparam int PW = $clog2(NUM_REQ);

    typedef enum logic [2:0] {IDLE, LOCKED, LAUNCH, WAIT_ACK, WAIT_DONE} state_t;

    state_t        state, state_n;
    logic [PW-1:0] ptr, gidx, win;
    logic [3:0]    cnt;
    logic          last_q, accept, rel;

    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] a, input int b);
        int s;
        s = int'(a) + b;
        return PW'(s >= NUM_REQ ? s - NUM_REQ : s);
    endfunction

    // Round-robin pick: the smallest offset from ptr wins, so offsets are scanned high to low
    always_comb begin
        win = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (req_valid[wrap_add(ptr, k)]) win = wrap_add(ptr, k);
    end

    // State register
    always_ff @(posedge clk) state <= rst ? IDLE : state_n;

    // Next state, handshake and per-state strobes; the release step is shared by timeout and busy-fall
    always_comb begin
        state_n   = state;
        req_ready = '0;
        tx_start  = 1'b0;
        ack_err   = 1'b0;
        accept    = 1'b0;
        rel       = 1'b0;
        case (state)
            IDLE:      state_n = |req_valid ? LOCKED : IDLE;
            LOCKED: begin
                req_ready = tx_busy ? '0 : grant;
                accept    = !tx_busy && req_valid[gidx];
                state_n   = accept ? LAUNCH : LOCKED;
            end
            LAUNCH: begin
                tx_start = 1'b1;
                state_n  = WAIT_ACK;
            end
            WAIT_ACK: begin
                ack_err = !tx_busy && cnt == 4'(ACK_TIMEOUT - 1);
                rel     = ack_err;
                state_n = tx_busy ? WAIT_DONE : WAIT_ACK;
            end
            WAIT_DONE: rel = !tx_busy;
            default:   state_n = IDLE;
        endcase
        if (rel) state_n = last_q ? IDLE : LOCKED;
    end

    // Owner, round-robin pointer, launched byte and busy-response watchdog
    always_ff @(posedge clk) begin
        if (rst) begin
            grant   <= '0;
            ptr     <= '0;
            gidx    <= '0;
            tx_data <= 8'h00;
            last_q  <= 1'b0;
            cnt     <= '0;
        end else begin
            if (state == IDLE && |req_valid) begin
                gidx  <= win;
                grant <= NUM_REQ'(1) << win;
            end
            if (accept) begin
                tx_data <= req_data[{gidx, 3'b000} +: 8];
                last_q  <= req_last[gidx];
            end
            cnt <= state == LAUNCH ? '0 : state == WAIT_ACK ? cnt + 4'd1 : cnt;
            if (rel && last_q) begin
                grant <= '0;
                ptr   <= wrap_add(gidx, 1);
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for the shared UART transmitter arbiter
module tb_uart_tx_arbiter;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_last = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   grant;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_busy;
    logic           ack_err;

    logic model_en = 1'b1;
    logic model_raise = 1'b1;
    logic force_busy = 1'b0;
    int   busy_len = 3;
    int   rem = 0;

    logic [7:0]   exp_q[$];
    logic [N-1:0] glog[$];
    logic [7:0]   exp_b;
    int           checks = 0;
    int           errors = 0;
    int           start_cnt = 0;
    logic         prev_start = 1'b0;
    logic [N-1:0] prev_grant = '0;

    logic [8:0]   lane_mem [N][8];
    int           lane_rd [N];
    int           lane_wr [N];
    int           hold [N];
    logic [N-1:0] acc_q = '0;

    uart_tx_arbiter #(.NUM_REQ(N), .ACK_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .grant(grant),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .ack_err(ack_err)
    );

    always #5 clk = ~clk;

    assign tx_busy = model_en ? (rem != 0) : force_busy;

    // Transmitter model: busy for busy_len cycles starting the cycle after tx_start
    always @(posedge clk) begin
        if (tx_start && model_en && model_raise) rem <= busy_len;
        else if (rem > 0) rem <= rem - 1;
    end

    // Scoreboard: every launch pops the next expected byte; also logs each new grant
    always @(negedge clk) begin
        if (tx_start) begin
            start_cnt++;
            checks++;
            if (prev_start) begin
                errors++;
                $display("FAIL tx_start_width: high on two consecutive cycles, required one");
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_extra: got byte %h, required no launch", tx_data);
            end else begin
                exp_b = exp_q.pop_front();
                if (tx_data !== exp_b) begin
                    errors++;
                    $display("FAIL scoreboard_data: got %h, required %h", tx_data, exp_b);
                end
            end
        end
        if (grant !== prev_grant && grant !== '0) glog.push_back(grant);
        prev_start = tx_start;
        prev_grant = grant;
    end

    task automatic clear_lanes();
        for (int i = 0; i < N; i++) begin
            lane_rd[i] = 0;
            lane_wr[i] = 0;
            hold[i] = 0;
        end
        acc_q = '0;
        req_valid = '0;
    endtask

    task automatic push_byte(input int i, input logic last, input logic [7:0] d);
        lane_mem[i][lane_wr[i]] = {last, d};
        lane_wr[i]++;
    endtask

    task automatic apply_lanes();
        for (int i = 0; i < N; i++) begin
            if (acc_q[i]) lane_rd[i]++;
            if (hold[i] > 0) begin
                hold[i]--;
                req_valid[i] = 1'b0;
            end else begin
                req_valid[i] = lane_rd[i] < lane_wr[i];
            end
            if (lane_rd[i] < lane_wr[i]) begin
                req_data[8*i +: 8] = lane_mem[i][lane_rd[i]][7:0];
                req_last[i] = lane_mem[i][lane_rd[i]][8];
            end
        end
        acc_q = '0;
    endtask

    task automatic step();
        @(posedge clk); #1;
        apply_lanes();
        @(negedge clk);
        acc_q = req_valid & req_ready;
    endtask

    task automatic run_until_idle(input string name, input int max);
        bit done = 1'b0;
        bit drained;
        for (int c = 0; c < max && !done; c++) begin
            step();
            drained = 1'b1;
            for (int i = 0; i < N; i++) if (lane_rd[i] < lane_wr[i]) drained = 1'b0;
            done = exp_q.size() == 0 && grant == '0 && drained;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_timeout: not idle after %0d cycles, %0d bytes outstanding", name, max, exp_q.size());
        end
    endtask

    task automatic wait_start(input string name);
        bit seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            step();
            seen = tx_start;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_start_timeout: got no tx_start, required one", name);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        clear_lanes();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks += 6;
        if (grant !== '0) begin errors++; $display("FAIL reset_grant: got %b, required 0000", grant); end
        if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b, required 0", tx_start); end
        if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h, required 00", tx_data); end
        if (ack_err !== 1'b0) begin errors++; $display("FAIL reset_ack_err: got %b, required 0", ack_err); end
        if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready: got %b, required 0000", req_ready); end
        if (dut.ptr !== 2'd0) begin errors++; $display("FAIL reset_ptr: got %0d, required 0", dut.ptr); end
    endtask

    task automatic test_single_byte();
        bit seen = 1'b0;
        bit fell = 1'b0;
        clear_lanes();
        busy_len = 10;
        start_cnt = 0;
        push_byte(2, 1'b1, 8'hA5);
        exp_q.push_back(8'hA5);
        step();
        checks++;
        if (grant !== 4'b0000) begin errors++; $display("FAIL single_grant_n: got %b, required 0000", grant); end
        step();
        checks += 2;
        if (grant !== 4'b0100) begin errors++; $display("FAIL single_grant_n1: got %b, required 0100", grant); end
        if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready_n1: got %b, required 0100", req_ready); end
        step();
        checks += 2;
        if (tx_start !== 1'b1) begin errors++; $display("FAIL single_start_n2: got %b, required 1", tx_start); end
        if (tx_data !== 8'hA5) begin errors++; $display("FAIL single_data_n2: got %h, required a5", tx_data); end
        for (int c = 0; c < 40 && !fell; c++) begin
            step();
            if (tx_busy) seen = 1'b1;
            else if (seen) fell = 1'b1;
        end
        checks += 2;
        if (!fell) begin errors++; $display("FAIL single_busy_fall: got no busy fall, required one"); end
        if (grant !== 4'b0100) begin errors++; $display("FAIL single_grant_held: got %b, required 0100", grant); end
        step();
        checks += 3;
        if (grant !== 4'b0000) begin errors++; $display("FAIL single_grant_release: got %b, required 0000", grant); end
        if (dut.ptr !== 2'd3) begin errors++; $display("FAIL single_ptr: got %0d, required 3", dut.ptr); end
        if (start_cnt !== 1) begin errors++; $display("FAIL single_start_count: got %0d, required 1", start_cnt); end
        busy_len = 3;
    endtask

    task automatic test_round_robin();
        logic [N-1:0] order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        start_cnt = 0;
        glog.delete();
        push_byte(0, 1'b1, 8'h20);
        push_byte(0, 1'b1, 8'h24);
        push_byte(1, 1'b1, 8'h21);
        push_byte(2, 1'b1, 8'h22);
        push_byte(3, 1'b1, 8'h23);
        exp_q = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24};
        run_until_idle("rr", 300);
        checks += 2;
        if (glog.size() !== 5) begin errors++; $display("FAIL rr_grant_count: got %0d, required 5", glog.size()); end
        if (start_cnt !== 5) begin errors++; $display("FAIL rr_start_count: got %0d, required 5", start_cnt); end
        for (int i = 0; i < 5 && i < glog.size(); i++) begin
            checks++;
            if (glog[i] !== order[i]) begin errors++; $display("FAIL rr_order_%0d: got %b, required %b", i, glog[i], order[i]); end
        end
    endtask

    task automatic test_packet_lock();
        bit locked = 1'b0;
        bit done = 1'b0;
        clear_lanes();
        glog.delete();
        push_byte(1, 1'b0, 8'h10);
        push_byte(1, 1'b0, 8'h11);
        push_byte(1, 1'b1, 8'h12);
        push_byte(0, 1'b1, 8'h30);
        exp_q = '{8'h10, 8'h11, 8'h12, 8'h30};
        for (int c = 0; c < 200 && !done; c++) begin
            step();
            if (grant == 4'b0010) locked = 1'b1;
            if (acc_q[1] && lane_rd[1] == 1) hold[1] = 5;
            if (locked && lane_rd[1] < 3) begin
                checks += 2;
                if (grant !== 4'b0010) begin errors++; $display("FAIL lock_grant: got %b, required 0010", grant); end
                if (req_ready[0] !== 1'b0) begin errors++; $display("FAIL lock_ready0: got %b, required 0", req_ready[0]); end
            end
            done = exp_q.size() == 0 && grant == '0 && lane_rd[0] == 1;
        end
        checks += 2;
        if (!done) begin errors++; $display("FAIL lock_timeout: %0d bytes outstanding, required 0", exp_q.size()); end
        if (glog.size() !== 2) begin errors++; $display("FAIL lock_grant_count: got %0d, required 2", glog.size()); end
        if (glog.size() == 2) begin
            checks += 2;
            if (glog[0] !== 4'b0010) begin errors++; $display("FAIL lock_first_grant: got %b, required 0010", glog[0]); end
            if (glog[1] !== 4'b0001) begin errors++; $display("FAIL lock_next_grant: got %b, required 0001", glog[1]); end
        end
    endtask

    task automatic test_busy_at_grant();
        clear_lanes();
        model_en = 1'b0;
        force_busy = 1'b1;
        push_byte(3, 1'b1, 8'h5C);
        exp_q.push_back(8'h5C);
        step();
        step();
        checks += 2;
        if (grant !== 4'b1000) begin errors++; $display("FAIL busy_grant: got %b, required 1000", grant); end
        if (req_ready !== 4'b0000) begin errors++; $display("FAIL busy_ready_grant: got %b, required 0000", req_ready); end
        repeat (3) begin
            step();
            checks += 2;
            if (req_ready !== 4'b0000) begin errors++; $display("FAIL busy_ready_held: got %b, required 0000", req_ready); end
            if (tx_start !== 1'b0) begin errors++; $display("FAIL busy_no_start: got %b, required 0", tx_start); end
        end
        @(posedge clk); #1;
        force_busy = 1'b0;
        model_en = 1'b1;
        apply_lanes();
        @(negedge clk);
        acc_q = req_valid & req_ready;
        checks += 2;
        if (req_ready !== 4'b1000) begin errors++; $display("FAIL busy_ready_after_fall: got %b, required 1000", req_ready); end
        if (tx_start !== 1'b0) begin errors++; $display("FAIL busy_start_early: got %b, required 0", tx_start); end
        step();
        checks++;
        if (tx_start !== 1'b1) begin errors++; $display("FAIL busy_start: got %b, required 1", tx_start); end
        run_until_idle("busy", 50);
    endtask

    task automatic test_watchdog();
        clear_lanes();
        model_raise = 1'b0;
        push_byte(1, 1'b1, 8'h77);
        exp_q.push_back(8'h77);
        wait_start("wdog");
        for (int k = 1; k <= 4; k++) begin
            step();
            checks++;
            if (ack_err !== (k == 4)) begin errors++; $display("FAIL wdog_ack_err_%0d: got %b, required %b", k, ack_err, k == 4); end
        end
        step();
        checks += 3;
        if (grant !== 4'b0000) begin errors++; $display("FAIL wdog_release: got %b, required 0000", grant); end
        if (ack_err !== 1'b0) begin errors++; $display("FAIL wdog_ack_width: got %b, required 0", ack_err); end
        if (dut.ptr !== 2'd2) begin errors++; $display("FAIL wdog_ptr: got %0d, required 2", dut.ptr); end
        model_raise = 1'b1;
    endtask

    task automatic test_reset_mid_packet();
        clear_lanes();
        busy_len = 10;
        push_byte(2, 1'b0, 8'h99);
        exp_q.push_back(8'h99);
        wait_start("rstmid");
        step();
        step();
        checks += 2;
        if (tx_busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy: got %b, required 1", tx_busy); end
        if (grant !== 4'b0100) begin errors++; $display("FAIL rstmid_grant_before: got %b, required 0100", grant); end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks += 4;
        if (grant !== 4'b0000) begin errors++; $display("FAIL rstmid_grant: got %b, required 0000", grant); end
        if (tx_start !== 1'b0) begin errors++; $display("FAIL rstmid_tx_start: got %b, required 0", tx_start); end
        if (dut.ptr !== 2'd0) begin errors++; $display("FAIL rstmid_ptr: got %0d, required 0", dut.ptr); end
        if (req_ready !== 4'b0000) begin errors++; $display("FAIL rstmid_ready: got %b, required 0000", req_ready); end
        clear_lanes();
        glog.delete();
        push_byte(1, 1'b1, 8'hB1);
        push_byte(3, 1'b1, 8'hB3);
        exp_q = '{8'hB1, 8'hB3};
        step();
        step();
        checks++;
        if (grant !== 4'b0010) begin errors++; $display("FAIL rstmid_restart_grant: got %b, required 0010", grant); end
        run_until_idle("rstmid", 100);
        checks++;
        if (glog.size() !== 2 || glog[0] !== 4'b0010 || glog[1] !== 4'b1000)
            begin errors++; $display("FAIL rstmid_order: got %0d grants, required 0010 then 1000", glog.size()); end
        busy_len = 3;
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_round_robin();
        test_packet_lock();
        test_busy_at_grant();
        test_watchdog();
        test_reset_mid_packet();
        checks++;
        if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_left: got %0d bytes pending, required 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
